// File: rtl/i2s_tdm_receive.sv
// I2S/TDM serial receiver: recovers per-slot samples and queues them on an AXI-Stream master.
// Latency: a word is pushed on the clock of its last data bit; TVALID rises the next clock.
// Backpressure: a small FIFO absorbs stalls; a word arriving to a full, non-popping FIFO is dropped.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             head_vld,
  output logic             drop
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign head_vld = !empty;
  assign head_dat = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module i2s_tdm_receive #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  M_AXIS_ACLK,
  input  logic                  M_AXIS_ARESET,
  input  logic                  sck,
  input  logic                  ws,
  input  logic                  sd,
  input  logic                  mode,
  output logic                  M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic [((CHANNELS > 2) ? $clog2(CHANNELS) : 1)-1:0] M_AXIS_TUSER,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic                  locked,
  output logic                  frame_err,
  output logic                  overflow
);
  localparam int UW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  localparam int BW = 6;
  localparam logic [BW-1:0] LAST_BIT  = BW'(SLOT_WIDTH - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] DATA_BITS = BW'(DATA_WIDTH);
  localparam logic [UW-1:0] SLOT_LAST = UW'(CHANNELS - 1);

  typedef enum logic [1:0] {HUNT, RUN, WAIT_START} state_t;

  logic [1:0] sck_sync;
  logic [1:0] ws_sync;
  logic [1:0] sd_sync;
  logic       sck_d;
  logic       ws_prev;
  logic       sck_s;
  logic       ws_s;
  logic       sd_s;
  logic       sck_rise;
  logic       frame_start;

  state_t          state;
  state_t          state_next;
  logic            cur_mode;
  logic [BW-1:0]   bit_cnt;
  logic [UW-1:0]   slot_cnt;
  logic [BW-1:0]   wait_cnt;
  logic [DATA_WIDTH-2:0] sh;
  logic            last_bit;
  logic            wait_last;

  logic            take_bit;
  logic            restart;
  logic            err;
  logic            lock_set;

  logic            push;
  logic [UW+DATA_WIDTH-1:0] push_dat;
  logic [UW+DATA_WIDTH-1:0] head_dat;
  logic            head_vld;
  logic            drop;

  assign sck_s = sck_sync[1];
  assign ws_s  = ws_sync[1];
  assign sd_s  = sd_sync[1];

  // Two-flop synchronisers for the serial inputs; all three share the same delay so they stay aligned.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
    end else begin
      sck_sync <= {sck_sync[0], sck};
      ws_sync  <= {ws_sync[0], ws};
      sd_sync  <= {sd_sync[0], sd};
    end
  end

  // Bit-clock edge detect and word-select history sampled only on bit-clock rises.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      sck_d   <= 1'b0;
      ws_prev <= 1'b0;
    end else begin
      sck_d <= sck_s;
      if (sck_rise) ws_prev <= ws_s;
    end
  end

  assign sck_rise    = sck_s && !sck_d;
  assign frame_start = sck_rise && ws_prev && !ws_s;
  assign last_bit    = (slot_cnt == SLOT_LAST) && (bit_cnt == LAST_BIT);
  assign wait_last   = (wait_cnt == LAST_BIT);

  // Frame state register.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) state <= HUNT;
    else               state <= state_next;
  end

  // Next-state logic. A restart always lands in RUN, even when the same rise also closes a frame.
  always_comb begin
    state_next = state;
    case (state)
      HUNT:       if (restart) state_next = RUN;
      RUN:        if (!restart && take_bit && last_bit) state_next = WAIT_START;
      WAIT_START: if (restart) state_next = RUN;
                  else if (err) state_next = HUNT;
      default:    state_next = HUNT;
    endcase
  end

  // Control decode. In I2S mode the frame-start rise still carries the final bit of the old frame,
  // so a frame start exactly on that bit is a legal frame boundary rather than an early one.
  always_comb begin
    take_bit = 1'b0;
    restart  = 1'b0;
    err      = 1'b0;
    lock_set = 1'b0;
    case (state)
      HUNT: begin
        if (frame_start) restart = 1'b1;
      end
      RUN: begin
        if (frame_start) begin
          restart = 1'b1;
          if (!cur_mode && last_bit) begin
            take_bit = 1'b1;
            lock_set = 1'b1;
          end else begin
            err = 1'b1;
          end
        end else if (sck_rise) begin
          take_bit = 1'b1;
        end
      end
      WAIT_START: begin
        if (frame_start) begin
          restart  = 1'b1;
          lock_set = 1'b1;
        end else if (sck_rise && wait_last) begin
          err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign push     = take_bit && (bit_cnt == DATA_LAST);
  assign push_dat = {slot_cnt, sh, sd_s};

  // Bit/slot counters, shift register and status flags; restart overrides the counter advance.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      cur_mode  <= 1'b0;
      bit_cnt   <= '0;
      slot_cnt  <= '0;
      wait_cnt  <= '0;
      sh        <= '0;
      locked    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err;
      if (err)           locked <= 1'b0;
      else if (lock_set) locked <= 1'b1;

      if (state != WAIT_START) wait_cnt <= '0;
      else if (sck_rise)       wait_cnt <= wait_cnt + 1'b1;

      if (take_bit) begin
        if (bit_cnt < DATA_BITS) sh <= {sh[DATA_WIDTH-3:0], sd_s};
        if (bit_cnt == LAST_BIT) begin
          bit_cnt  <= '0;
          slot_cnt <= (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (restart) begin
        cur_mode <= mode;
        slot_cnt <= '0;
        if (mode) begin
          bit_cnt <= BW'(1);
          sh      <= {{(DATA_WIDTH-2){1'b0}}, sd_s};
        end else begin
          bit_cnt <= '0;
        end
      end
    end
  end

  // Sticky drop indicator, cleared only by reset.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) overflow <= 1'b0;
    else if (drop)     overflow <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (UW + DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (M_AXIS_ACLK),
    .rst      (M_AXIS_ARESET),
    .push     (push),
    .push_dat (push_dat),
    .pop      (M_AXIS_TREADY),
    .head_dat (head_dat),
    .head_vld (head_vld),
    .drop     (drop)
  );

  assign M_AXIS_TVALID = head_vld;
  assign M_AXIS_TDATA  = head_dat[DATA_WIDTH-1:0];
  assign M_AXIS_TUSER  = head_dat[DATA_WIDTH +: UW];
  assign M_AXIS_TLAST  = head_vld && (M_AXIS_TUSER == SLOT_LAST);
endmodule

// File: tb/tb_i2s_tdm_receive.sv
// Bench for i2s_tdm_receive: two instances (stereo I2S, 4-slot TDM) driven by directed frames.
// Expected beats are queued as frames are issued; a negedge monitor pops and compares accepted beats.
// Status flags are checked directly at settled points between frames.

module tb_i2s_tdm_receive;
  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  u;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck_a = 1'b0;
  logic sck_b = 1'b0;
  logic ws = 1'b1;
  logic sd = 1'b0;
  logic mode_a = 1'b0;
  logic mode_b = 1'b1;
  logic trdy_a = 1'b1;
  logic trdy_b = 1'b1;

  logic        tv_a, tl_a, tu_a, lk_a, fe_a, ov_a;
  logic [23:0] td_a;
  logic        tv_b, tl_b, lk_b, fe_b, ov_b;
  logic [15:0] td_b;
  logic [1:0]  tu_b;

  int checks = 0;
  int failures = 0;
  beat_t qa[$];
  beat_t qb[$];
  int err_cnt_a = 0;
  int err_cnt_b = 0;
  logic err_long = 1'b0;
  logic fe_a_q = 1'b0;
  logic fe_b_q = 1'b0;

  always #5 clk = ~clk;

  i2s_tdm_receive dut_a (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst), .sck(sck_a), .ws(ws), .sd(sd), .mode(mode_a),
    .M_AXIS_TVALID(tv_a), .M_AXIS_TDATA(td_a), .M_AXIS_TUSER(tu_a), .M_AXIS_TLAST(tl_a),
    .M_AXIS_TREADY(trdy_a), .locked(lk_a), .frame_err(fe_a), .overflow(ov_a)
  );

  i2s_tdm_receive #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .CHANNELS(4), .FIFO_DEPTH(4)) dut_b (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst), .sck(sck_b), .ws(ws), .sd(sd), .mode(mode_b),
    .M_AXIS_TVALID(tv_b), .M_AXIS_TDATA(td_b), .M_AXIS_TUSER(tu_b), .M_AXIS_TLAST(tl_b),
    .M_AXIS_TREADY(trdy_b), .locked(lk_b), .frame_err(fe_b), .overflow(ov_b)
  );

  // Scoreboard monitor and frame_err pulse tracking.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && tv_a && trdy_a) begin
      checks++;
      if (qa.size() == 0) begin
        failures++;
        $display("FAIL beat_a unexpected data=%h user=%0d last=%0b", td_a, tu_a, tl_a);
      end else begin
        e = qa.pop_front();
        if (td_a !== e.d[23:0] || tu_a !== e.u[0] || tl_a !== e.l) begin
          failures++;
          $display("FAIL beat_a got data=%h user=%0d last=%0b want data=%h user=%0d last=%0b",
                   td_a, tu_a, tl_a, e.d[23:0], e.u[0], e.l);
        end
      end
    end
    if (!rst && tv_b && trdy_b) begin
      checks++;
      if (qb.size() == 0) begin
        failures++;
        $display("FAIL beat_b unexpected data=%h user=%0d last=%0b", td_b, tu_b, tl_b);
      end else begin
        e = qb.pop_front();
        if (td_b !== e.d[15:0] || tu_b !== e.u[1:0] || tl_b !== e.l) begin
          failures++;
          $display("FAIL beat_b got data=%h user=%0d last=%0b want data=%h user=%0d last=%0b",
                   td_b, tu_b, tl_b, e.d[15:0], e.u[1:0], e.l);
        end
      end
    end
    if (fe_a && !fe_a_q) err_cnt_a++;
    if (fe_b && !fe_b_q) err_cnt_b++;
    if ((fe_a && fe_a_q) || (fe_b && fe_b_q)) err_long = 1'b1;
    fe_a_q = fe_a;
    fe_b_q = fe_b;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic rise(input logic w, input logic d, input int sel);
    ws = w;
    sd = d;
    #40;
    if (sel == 0) sck_a = 1'b1;
    else          sck_b = 1'b1;
    #40;
    sck_a = 1'b0;
    sck_b = 1'b0;
  endtask

  // Rise j=0 is the frame-start rise. In I2S mode bit k lands on rise k+1.
  // ws is high during the last slot (tail_ws) so the next frame's rise 0 is a frame start;
  // a truncated frame raises ws on its final rise to force an early frame start.
  task automatic send_frame(input int sel, input logic md, input int ch, input int sw, input int dw,
                            input logic [3:0][31:0] w, input int len, input logic tail_ws);
    int f;
    int k;
    logic d;
    logic wv;
    f = ch * sw;
    for (int j = 0; j < len; j++) begin
      k = md ? j : j - 1;
      d = 1'b0;
      if (k >= 0 && k < f && (k % sw) < dw) d = w[k / sw][dw - 1 - (k % sw)];
      wv = (j >= f - sw) ? tail_ws : 1'b0;
      if (len < f && j == len - 1) wv = 1'b1;
      rise(wv, d, sel);
    end
  endtask

  task automatic exp_a(input logic [31:0] d, input int slot);
    qa.push_back({d, 3'(slot), (slot == 1)});
  endtask

  task automatic exp_b(input logic [31:0] d, input int slot);
    qb.push_back({d, 3'(slot), (slot == 3)});
  endtask

  task automatic drain(input int sel, input int budget);
    int n;
    n = 0;
    while (((sel == 0) ? qa.size() : qb.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sel == 0) chk("drain_a_queue_left", qa.size(), 0);
    else          chk("drain_b_queue_left", qb.size(), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid_a", tv_a, 0);
    chk("rst_tdata_a", td_a, 0);
    chk("rst_tlast_a", tl_a, 0);
    chk("rst_locked_a", lk_a, 0);
    chk("rst_overflow_a", ov_a, 0);
    chk("rst_frame_err_a", fe_a, 0);
    chk("rst_tvalid_b", tv_b, 0);
    chk("rst_locked_b", lk_b, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Stereo I2S capture, lock on second frame start
    rise(1'b1, 1'b0, 0);
    rise(1'b1, 1'b0, 0);
    exp_a(32'hABCDEF, 0); exp_a(32'h123456, 1);
    send_frame(0, 1'b0, 2, 32, 24, {32'h0, 32'h0, 32'h123456, 32'hABCDEF}, 64, 1'b1);
    settle();
    chk("locked_after_first_frame", lk_a, 0);
    exp_a(32'h000001, 0); exp_a(32'hFFFFFF, 1);
    send_frame(0, 1'b0, 2, 32, 24, {32'h0, 32'h0, 32'hFFFFFF, 32'h000001}, 64, 1'b1);
    settle();
    chk("locked_after_second_start", lk_a, 1);
    drain(0, 200);
    chk("no_err_normal_frames", err_cnt_a, 0);

    // Early frame start after 40 bits: slot-1 partial dropped, next frame from slot 0
    exp_a(32'h111111, 0);
    send_frame(0, 1'b0, 2, 32, 24, {32'h0, 32'h0, 32'h222222, 32'h111111}, 41, 1'b1);
    exp_a(32'h333333, 0); exp_a(32'h444444, 1);
    send_frame(0, 1'b0, 2, 32, 24, {32'h0, 32'h0, 32'h444444, 32'h333333}, 64, 1'b1);
    settle();
    chk("early_err_count", err_cnt_a, 1);
    chk("early_locked_cleared", lk_a, 0);
    drain(0, 200);

    // One more frame, then ws held low for three frame lengths
    exp_a(32'h555555, 0); exp_a(32'h666666, 1);
    send_frame(0, 1'b0, 2, 32, 24, {32'h0, 32'h0, 32'h666666, 32'h555555}, 64, 1'b0);
    settle();
    chk("relock_after_good_start", lk_a, 1);
    for (int i = 0; i < 192; i++) rise(1'b0, i[0], 0);
    settle();
    chk("ws_stuck_err_count", err_cnt_a, 2);
    chk("ws_stuck_locked_cleared", lk_a, 0);
    drain(0, 200);

    // Overflow: TREADY low, six words into a four-deep FIFO
    trdy_a = 1'b0;
    rise(1'b1, 1'b0, 0);
    exp_a(32'hA00001, 0); exp_a(32'hA00002, 1);
    send_frame(0, 1'b0, 2, 32, 24, {32'h0, 32'h0, 32'hA00002, 32'hA00001}, 64, 1'b1);
    settle();
    chk("no_overflow_at_two_words", ov_a, 0);
    exp_a(32'hA00003, 0); exp_a(32'hA00004, 1);
    send_frame(0, 1'b0, 2, 32, 24, {32'h0, 32'h0, 32'hA00004, 32'hA00003}, 64, 1'b1);
    send_frame(0, 1'b0, 2, 32, 24, {32'h0, 32'h0, 32'hA00006, 32'hA00005}, 64, 1'b1);
    settle();
    chk("overflow_set", ov_a, 1);
    chk("tdata_held_head", td_a, 32'hA00001);
    trdy_a = 1'b1;
    drain(0, 200);
    repeat (4) @(posedge clk);
    #1;
    chk("overflow_sticky", ov_a, 1);

    // Reset with three words buffered, mid-frame
    trdy_a = 1'b0;
    send_frame(0, 1'b0, 2, 32, 24, {32'h0, 32'h0, 32'hB00002, 32'hB00001}, 64, 1'b1);
    send_frame(0, 1'b0, 2, 32, 24, {32'h0, 32'h0, 32'hB00004, 32'hB00003}, 31, 1'b1);
    settle();
    chk("buffered_tvalid", tv_a, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_tvalid_next_clk", tv_a, 0);
    chk("reset_overflow_cleared", ov_a, 0);
    chk("reset_locked_cleared", lk_a, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    trdy_a = 1'b1;
    for (int i = 0; i < 40; i++) rise(1'b0, 1'b1, 0);
    settle();
    chk("no_beat_before_frame_start", tv_a, 0);
    rise(1'b1, 1'b0, 0);
    exp_a(32'h0F0F0F, 0); exp_a(32'hF0F0F0, 1);
    send_frame(0, 1'b0, 2, 32, 24, {32'h0, 32'h0, 32'hF0F0F0, 32'h0F0F0F}, 64, 1'b1);
    drain(0, 200);

    // 4-slot TDM, left-justified, 16-bit slots
    rise(1'b1, 1'b0, 1);
    exp_b(32'h1111, 0); exp_b(32'h2222, 1); exp_b(32'h3333, 2); exp_b(32'h4444, 3);
    send_frame(1, 1'b1, 4, 16, 16, {32'h4444, 32'h3333, 32'h2222, 32'h1111}, 64, 1'b1);
    settle();
    chk("tdm_locked_after_first", lk_b, 0);
    exp_b(32'hA5A5, 0); exp_b(32'h0001, 1); exp_b(32'h8000, 2); exp_b(32'hFFFF, 3);
    send_frame(1, 1'b1, 4, 16, 16, {32'hFFFF, 32'h8000, 32'h0001, 32'hA5A5}, 64, 1'b1);
    settle();
    chk("tdm_locked_after_second", lk_b, 1);
    chk("tdm_no_err", err_cnt_b, 0);
    drain(1, 200);

    chk("frame_err_single_cycle", err_long, 0);
    chk("tdm_overflow_clear", ov_b, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2s_tdm_receive.md
I2S_TDM_RECEIVE -- requirements
Module: i2s_tdm_receive

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, captured bits per slot (8..32).
REQ-002 SHALL have parameter SLOT_WIDTH, default 32, sck periods per slot (DATA_WIDTH..32).
REQ-003 SHALL have parameter CHANNELS, default 2, slots per frame (2..8).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output FIFO words (power of two, 2..16).
REQ-005 SHALL have port M_AXIS_ACLK  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port M_AXIS_ARESET  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports sck, ws, sd  in  1 each  asynchronous I2S/TDM bit clock, word select, serial data.
REQ-008 SHALL have port mode  in  1  0 = I2S (MSB one sck after frame edge), 1 = left-justified (MSB on frame edge).
REQ-009 SHALL have port M_AXIS_TVALID  out  1  FIFO head valid.
REQ-010 SHALL have port M_AXIS_TDATA  out  DATA_WIDTH  sample, MSB = first received bit.
REQ-011 SHALL have port M_AXIS_TUSER  out  max(1,clog2(CHANNELS))  slot index of sample.
REQ-012 SHALL have port M_AXIS_TLAST  out  1  high when TUSER = CHANNELS-1.
REQ-013 SHALL have port M_AXIS_TREADY  in  1  downstream accept.
REQ-014 SHALL have ports locked, frame_err, overflow  out  1 each  frame lock, 1-cycle error pulse, sticky FIFO drop flag.

Function
REQ-015 SHALL pass sck, ws, sd through 2-flop synchronisers; sck_rise = synchronised sck 0->1; all serial sampling on sck_rise only; M_AXIS_ACLK >= 4x sck frequency.
REQ-016 SHALL define frame start as ws sampled 1 at previous sck_rise and 0 at current sck_rise; ws mid-frame transitions otherwise ignored.
REQ-017 SHALL latch mode at each frame start; mode changes mid-frame take effect at next frame start.
REQ-018 SHALL treat, mode=1, the bit at the frame-start sck_rise as slot 0 bit 0; mode=0, the bit at the following sck_rise.
REQ-019 SHALL count bits 0..SLOT_WIDTH-1 per slot, slot index 0..CHANNELS-1; capture bits 0..DATA_WIDTH-1 MSB-first; ignore bits DATA_WIDTH..SLOT_WIDTH-1.
REQ-020 SHALL, on the sck_rise capturing bit DATA_WIDTH-1, push {slot, word} into FIFO at that clock; TVALID SHALL rise the next clock if FIFO was empty.
REQ-021 SHALL, after reset or error, discard bits until a frame start (state states: HUNT, RUN, WAIT_START).
REQ-022 SHALL, in RUN, move to WAIT_START after CHANNELS*SLOT_WIDTH bits; a frame start in WAIT_START SHALL set locked=1 and re-enter RUN.
REQ-023 SHALL, on frame start in RUN (early), pulse frame_err 1 cycle, clear locked, drop partial word, restart at slot 0 bit 0.
REQ-024 SHALL, if SLOT_WIDTH further sck_rise occur in WAIT_START without frame start, pulse frame_err, clear locked, enter HUNT.
REQ-025 SHALL emit complete words in RUN regardless of locked.
REQ-026 SHALL pop FIFO when TVALID && TREADY; TDATA/TUSER/TLAST stable while TVALID && !TREADY.
REQ-027 SHALL, on push with FIFO full and no pop same cycle, drop the new word and set overflow; push and pop same cycle when full SHALL both succeed.
REQ-028 SHALL keep overflow set until reset.

Reset
REQ-029 SHALL, while M_AXIS_ARESET=1 at a clock edge: TVALID=0, TDATA=0, TUSER=0, TLAST=0, locked=0, frame_err=0, overflow=0, FIFO empty, state HUNT, synchronisers cleared.
REQ-030 SHALL, on reset mid-frame or mid-transfer, discard all buffered and partial words; capture resumes at next frame start.

Verification
REQ-031 CHANNELS=2, mode=0, slots 0xABCDEF/0x123456, TREADY=1 -> beats (0xABCDEF,TUSER0,TLAST0),(0x123456,TUSER1,TLAST1); locked=1 after second frame start.
REQ-032 CHANNELS=4, mode=1, DATA_WIDTH=16, SLOT_WIDTH=16, slots 0x1111..0x4444 -> four beats in order, TLAST on 0x4444 only.
REQ-033 TREADY=0, FIFO_DEPTH=4, 5 words -> first 4 retained in order, 5th dropped, overflow=1 until reset.
REQ-034 CHANNELS=2, SLOT_WIDTH=32, frame start after 40 bits -> frame_err 1-cycle pulse, locked=0, slot-1 partial dropped, next frame captured from slot 0.
REQ-035 Reset asserted with 3 words buffered -> TVALID=0 next clock; post-reset words appear only after a new frame start.
REQ-036 ws held low 3 frame lengths after one frame -> frame_err pulse, locked=0, no further beats.
